// File: rtl/rgb_to_ycbcr422_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_ycbcr422_pkg
//  Description : Shared constants and types for the RGB888 -> YCbCr 4:2:2
//                converter: BT.601 limited-range coefficients, offsets,
//                clamp limits, pipeline latency and the control bundle that
//                travels alongside each pixel.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package rgb_to_ycbcr422_pkg;

    // Input-to-output delay of data, DE and syncs, in pixel clocks.
    localparam int C_PIPE_LAT = 4;

    // BT.601 limited-range matrix, scaled by 256.
    localparam int C_Y_R  =  66;
    localparam int C_Y_G  = 129;
    localparam int C_Y_B  =  25;
    localparam int C_CB_R = -38;
    localparam int C_CB_G = -74;
    localparam int C_CB_B = 112;
    localparam int C_CR_R = 112;
    localparam int C_CR_G = -94;
    localparam int C_CR_B = -18;

    // Rounding term added before the >>>8 rescale.
    localparam int C_ROUND = 128;

    localparam int C_Y_OFFSET = 16;
    localparam int C_C_OFFSET = 128;
    localparam int C_Y_MIN    = 16;
    localparam int C_Y_MAX    = 235;
    localparam int C_C_MIN    = 16;
    localparam int C_C_MAX    = 240;

    // Chroma value meaning "no colour".
    localparam logic [7:0] C_C_NEUTRAL = 8'h80;

    // Per-pixel control carried through the pipeline next to the data.
    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
        logic gray;
    } ctrl_t;

    // Saturate a signed intermediate to an 8-bit code in [lo, hi].
    function automatic logic [7:0] clamp_u8(input logic signed [17:0] v,
                                            input int lo, input int hi);
        logic [7:0] res;
        if (v < 18'(lo))
            res = 8'(lo);
        else if (v > 18'(hi))
            res = 8'(hi);
        else
            res = v[7:0];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_to_ycbcr422_if.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_ycbcr422_if
//  Description : Video bus between the pixel source and the HDMI transmitter
//                pins. Source side: grayscale, vsync, hsync, de, rgb
//                ({R,G,B}). HDMI side: hdmi_vsync, hdmi_hsync, hdmi_de,
//                hdmi_data ({Y,C}).
//                master : pixel source (drives RGB, observes HDMI side)
//                slave  : converter   (consumes RGB, drives HDMI side)
//  Revision    : 1.0  initial release
// ============================================================================
interface rgb_to_ycbcr422_if;
    logic        grayscale;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic [23:0] rgb;

    logic        hdmi_vsync;
    logic        hdmi_hsync;
    logic        hdmi_de;
    logic [15:0] hdmi_data;

    modport master (
        output grayscale, vsync, hsync, de, rgb,
        input  hdmi_vsync, hdmi_hsync, hdmi_de, hdmi_data
    );

    modport slave (
        input  grayscale, vsync, hsync, de, rgb,
        output hdmi_vsync, hdmi_hsync, hdmi_de, hdmi_data
    );
endinterface
`default_nettype wire

// File: rtl/rgb_to_ycbcr422_mac.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_ycbcr422_mac
//  Description : One output channel of the colour matrix. Three pipeline
//                stages:
//                  S1  three 8x8 unsigned products (coefficient magnitudes)
//                  S2  signed sum of the products plus the rounding term
//                  S3  arithmetic >>>8, add offset, clamp to [MIN, MAX]
//  Ports       : clk   in   1   pixel clock
//                rst   in   1   synchronous active-high reset
//                rgb   in   24  {R,G,B}
//                value out  8   clamped channel value, 3 cycles after rgb
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_to_ycbcr422_mac #(
    parameter int COEF_R  = 66,
    parameter int COEF_G  = 129,
    parameter int COEF_B  = 25,
    parameter int OFFSET  = 16,
    parameter int MIN_VAL = 16,
    parameter int MAX_VAL = 235
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    output logic [7:0]  value
);
    import rgb_to_ycbcr422_pkg::*;

    // Multipliers see only magnitudes; the sign is applied in the adder.
    localparam logic [7:0] C_MAG_R = 8'((COEF_R < 0) ? -COEF_R : COEF_R);
    localparam logic [7:0] C_MAG_G = 8'((COEF_G < 0) ? -COEF_G : COEF_G);
    localparam logic [7:0] C_MAG_B = 8'((COEF_B < 0) ? -COEF_B : COEF_B);
    localparam bit         C_NEG_R = (COEF_R < 0);
    localparam bit         C_NEG_G = (COEF_G < 0);
    localparam bit         C_NEG_B = (COEF_B < 0);

    localparam logic signed [17:0] C_RND = 18'(C_ROUND);
    localparam logic signed [17:0] C_OFS = 18'(OFFSET);

    logic [15:0]        r_prod_r;
    logic [15:0]        r_prod_g;
    logic [15:0]        r_prod_b;
    logic signed [17:0] r_sum;
    logic signed [17:0] w_scaled;
    logic [7:0]         r_value;

    function automatic logic signed [17:0] term(input logic [15:0] prod,
                                                input bit neg);
        logic signed [17:0] t;
        t = $signed({2'b00, prod});
        return neg ? -t : t;
    endfunction

    // S3 operand: divide by 256 rounding toward -inf, then apply offset.
    assign w_scaled = (r_sum >>> 8) + C_OFS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod_r <= '0;
            r_prod_g <= '0;
            r_prod_b <= '0;
            r_sum    <= '0;
            r_value  <= '0;
        end else begin
            r_prod_r <= {8'd0, rgb[23:16]} * {8'd0, C_MAG_R};
            r_prod_g <= {8'd0, rgb[15:8]}  * {8'd0, C_MAG_G};
            r_prod_b <= {8'd0, rgb[7:0]}   * {8'd0, C_MAG_B};
            r_sum    <= term(r_prod_r, C_NEG_R) + term(r_prod_g, C_NEG_G)
                      + term(r_prod_b, C_NEG_B) + C_RND;
            r_value  <= clamp_u8(w_scaled, MIN_VAL, MAX_VAL);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/rgb_to_ycbcr422.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_ycbcr422
//  Description : RGB888 + timing -> 16-bit YCbCr 4:2:2 for the ADV7511.
//                S1..S3 : three matrix channels (Y, Cb, Cr) in parallel with
//                         a control delay line (vsync, hsync, de, grayscale)
//                S4     : co-sited 4:2:2 chroma mux and blanking substitution
//                Fixed 4-cycle latency, one pixel per clock, no stalls.
//  Ports       : i_clk  in   1    pixel clock
//                i_rst  in   1    synchronous active-high reset
//                bus    slave      source RGB/timing in, {Y,C}/timing out
//  Parameters  : CB_FIRST  1: phase-0 pixel carries Cb, phase-1 Cr
//                BLANK_Y   Y driven while hdmi_de=0
//                BLANK_C   C driven while hdmi_de=0
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_to_ycbcr422 #(
    parameter bit         CB_FIRST = 1'b1,
    parameter logic [7:0] BLANK_Y  = 8'h10,
    parameter logic [7:0] BLANK_C  = 8'h80
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rgb_to_ycbcr422_if.slave   bus
);
    import rgb_to_ycbcr422_pkg::*;

    ctrl_t      w_ctrl_in;
    ctrl_t      r_ctrl_s1;
    ctrl_t      r_ctrl_s2;
    ctrl_t      r_ctrl_s3;

    logic [7:0] w_y;
    logic [7:0] w_cb_mac;
    logic [7:0] w_cr_mac;
    logic [7:0] w_cb;
    logic [7:0] w_cr;
    logic [7:0] w_c_first;
    logic [7:0] w_c_second;

    logic       r_vsync;
    logic       r_hsync;
    logic       r_de;
    logic [15:0] r_data;
    logic       r_phase;
    logic [7:0] r_c_hold;

    assign w_ctrl_in = {bus.vsync, bus.hsync, bus.de, bus.grayscale};

    rgb_to_ycbcr422_mac #(
        .COEF_R (C_Y_R), .COEF_G (C_Y_G), .COEF_B (C_Y_B),
        .OFFSET (C_Y_OFFSET), .MIN_VAL (C_Y_MIN), .MAX_VAL (C_Y_MAX)
    ) u_mac_y (
        .clk   (i_clk),
        .rst   (i_rst),
        .rgb   (bus.rgb),
        .value (w_y)
    );

    rgb_to_ycbcr422_mac #(
        .COEF_R (C_CB_R), .COEF_G (C_CB_G), .COEF_B (C_CB_B),
        .OFFSET (C_C_OFFSET), .MIN_VAL (C_C_MIN), .MAX_VAL (C_C_MAX)
    ) u_mac_cb (
        .clk   (i_clk),
        .rst   (i_rst),
        .rgb   (bus.rgb),
        .value (w_cb_mac)
    );

    rgb_to_ycbcr422_mac #(
        .COEF_R (C_CR_R), .COEF_G (C_CR_G), .COEF_B (C_CR_B),
        .OFFSET (C_C_OFFSET), .MIN_VAL (C_C_MIN), .MAX_VAL (C_C_MAX)
    ) u_mac_cr (
        .clk   (i_clk),
        .rst   (i_rst),
        .rgb   (bus.rgb),
        .value (w_cr_mac)
    );

    // Control travels three stages to line up with the MAC outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ctrl_s1 <= '0;
            r_ctrl_s2 <= '0;
            r_ctrl_s3 <= '0;
        end else begin
            r_ctrl_s1 <= w_ctrl_in;
            r_ctrl_s2 <= r_ctrl_s1;
            r_ctrl_s3 <= r_ctrl_s2;
        end
    end

    // Grayscale neutralises both chroma channels of its own pixel.
    assign w_cb       = r_ctrl_s3.gray ? C_C_NEUTRAL : w_cb_mac;
    assign w_cr       = r_ctrl_s3.gray ? C_C_NEUTRAL : w_cr_mac;
    assign w_c_first  = CB_FIRST ? w_cb : w_cr;
    assign w_c_second = CB_FIRST ? w_cr : w_cb;

    // 4:2:2 mux. The phase-0 pixel emits its first chroma and parks the
    // second in r_c_hold for its neighbour. A grayscale pixel in phase 1
    // still shows neutral chroma, so the override takes effect on exactly
    // the pixel that requested it. Any blank cycle restarts the pairing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync  <= 1'b0;
            r_hsync  <= 1'b0;
            r_de     <= 1'b0;
            r_data   <= {BLANK_Y, BLANK_C};
            r_phase  <= 1'b0;
            r_c_hold <= '0;
        end else begin
            r_vsync <= r_ctrl_s3.vsync;
            r_hsync <= r_ctrl_s3.hsync;
            r_de    <= r_ctrl_s3.de;
            if (r_ctrl_s3.de) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_data   <= {w_y, w_c_first};
                    r_c_hold <= w_c_second;
                end else begin
                    r_data <= {w_y, r_ctrl_s3.gray ? C_C_NEUTRAL : r_c_hold};
                end
            end else begin
                r_phase <= 1'b0;
                r_data  <= {BLANK_Y, BLANK_C};
            end
        end
    end

    assign bus.hdmi_vsync = r_vsync;
    assign bus.hdmi_hsync = r_hsync;
    assign bus.hdmi_de    = r_de;
    assign bus.hdmi_data  = r_data;

endmodule
`default_nettype wire
